dac_i2s_tx: RTL

Serializes the mono 16-bit processed audio stream onto the WM8731 DAC data line (AUD_DACDAT) in I2S format, slaved to codec-generated AUD_BCLK and AUD_DACLRCK. It is the playback-side counterpart of the mic capture path. It accepts decimated samples through a valid/ready port into a small FIFO, holds each sample for REPEAT frames (zero-order-hold upsampling, 12 kHz to 48 kHz), and sends the same word on the left and right channels.

---
 rtl/dac_i2s_tx_pkg.sv | 25 ++
 rtl/dac_i2s_tx_sync_fifo.sv | 65 ++++++
 rtl/dac_i2s_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dac_i2s_tx_pkg.sv
// Shared audio definitions for the playback path: sample type, I2S slot
// width, tone generator constants and the transmitter state encoding.
package dac_i2s_tx_pkg;

    localparam int SAMPLE_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Bits carried in each I2S channel slot (MSB first).
    localparam int SLOT_BITS = SAMPLE_W;

    // Test tone: +/-0x2000 square wave, toggling every 24 frames (1 kHz at 48 kHz).
    localparam sample_t TONE_AMP         = 16'sh2000;
    localparam int      TONE_HALF_FRAMES = 24;

    typedef enum logic [0:0] {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } tx_state_t;

    // Width of a counter that must hold values 0 .. max_val-1 (never zero width).
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/dac_i2s_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output, for stream buffers.
// Writes are ignored when full and reads ignored when empty; pointers wrap
// naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the registered count, so a full FIFO refuses a
    // write even in a cycle that also reads.
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: I2S serializer for the WM8731 DAC, slaved to the codec's
// AUD_BCLK / AUD_DACLRCK. Samples enter a small FIFO (s_valid/s_ready), each
// popped sample is held for REPEAT frames and sent on both channels.
// Optional build macro DAC_TONE_EN adds an internal square-wave test tone
// selected by tone_sel; without it tone_sel is ignored.
//
// Handshake: a word is transferred on a rising AUD_BCLK where s_valid and
// s_ready are both high; s_ready depends only on the registered FIFO count,
// and s_data must be stable while s_valid is high.
module dac_i2s_tx
    import dac_i2s_tx_pkg::*;
#(
    parameter int N          = SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT     = 4
) (
    input  logic                            AUD_BCLK,
    input  logic                            rst_n,
    input  logic                            AUD_DACLRCK,
    output logic                            AUD_DACDAT,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [N-1:0]                    s_data,
    input  logic                            tone_sel,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output tx_state_t                       o_dbg_state
);

    localparam int REP_W = cnt_width(REPEAT);

    tx_state_t      r_state;
    logic           r_lrck_q;
    logic           r_started;
    logic [REP_W-1:0] r_rep_cnt;
    logic [N-1:0]   r_cur;
    logic [N-1:0]   r_shift;
    logic           r_underrun;
    logic           r_dacdat;

    logic           w_fall;
    logic           w_rise;
    logic           w_pop;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [N-1:0]   w_fifo_rd_data;
    logic [N-1:0]   w_next_cur;
    logic [REP_W-1:0] w_next_rep;
    logic           w_set_underrun;

    // LRCK low = left slot, high = right slot; a fall starts a frame.
    assign w_fall = r_lrck_q & ~AUD_DACLRCK;
    assign w_rise = ~r_lrck_q & AUD_DACLRCK;

    assign s_ready     = ~w_fifo_full;
    assign underrun    = r_underrun;
    assign AUD_DACDAT  = r_dacdat;
    assign o_dbg_state = r_state;

    sync_fifo #(
        .W     (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (AUD_BCLK),
        .i_rst_n   (rst_n),
        .i_wr_en   (s_valid),
        .i_wr_data (s_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (fifo_level)
    );

`ifdef DAC_TONE_EN
    localparam int TONE_CW = cnt_width(TONE_HALF_FRAMES);

    logic [TONE_CW-1:0] r_tone_cnt;
    logic               r_tone_neg;
    logic [N-1:0]       w_tone_word;

    assign w_tone_word = r_tone_neg ? N'(-TONE_AMP) : N'(TONE_AMP);

    // Tone phase: counts frames while selected, restarts positive when deselected.
    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            r_tone_neg <= 1'b0;
        end else if (!tone_sel) begin
            r_tone_cnt <= '0;
            r_tone_neg <= 1'b0;
        end else if (w_fall) begin
            if (r_tone_cnt == TONE_CW'(TONE_HALF_FRAMES - 1)) begin
                r_tone_cnt <= '0;
                r_tone_neg <= ~r_tone_neg;
            end else begin
                r_tone_cnt <= r_tone_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_tone;
    assign w_unused_tone = tone_sel;
`endif

    // Frame-begin decision: new sample, zero on underrun, or keep holding.
    always_comb begin
        w_pop          = 1'b0;
        w_next_cur     = r_cur;
        w_next_rep     = r_rep_cnt;
        w_set_underrun = 1'b0;
        if (r_rep_cnt == '0) begin
            if (!w_fifo_empty) begin
                w_pop      = w_fall;
                w_next_cur = w_fifo_rd_data;
                w_next_rep = REP_W'(REPEAT - 1);
            end else begin
                w_next_cur     = '0;
                w_set_underrun = 1'b1;
            end
        end else begin
            w_next_rep = r_rep_cnt - 1'b1;
        end
`ifdef DAC_TONE_EN
        if (tone_sel) begin
            w_pop          = 1'b0;
            w_next_cur     = w_tone_word;
            w_next_rep     = r_rep_cnt;
            w_set_underrun = 1'b0;
        end
`endif
    end

    // Sync/run FSM with the slot shifter; a slot-start reload beats shifting.
    always_ff @(posedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT_SYNC;
            r_lrck_q   <= 1'b0;
            r_started  <= 1'b0;
            r_rep_cnt  <= '0;
            r_cur      <= '0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_lrck_q <= AUD_DACLRCK;
            if (w_fall) begin
                r_state   <= ST_RUN;
                r_started <= 1'b1;
                r_cur     <= w_next_cur;
                r_shift   <= w_next_cur;
                r_rep_cnt <= w_next_rep;
                if (w_set_underrun) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_rise && r_started) begin
                r_shift <= r_cur;
            end else begin
                r_shift <= {r_shift[N-2:0], 1'b0};
            end
        end
    end

    // Data changes on falling BCLK: one-bit I2S delay, half-cycle setup.
    always_ff @(negedge AUD_BCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_dacdat <= 1'b0;
        end else begin
            r_dacdat <= r_shift[N-1];
        end
    end

endmodule
